vec_fmul_round: RTL

Two-stage pipelined normalise-and-round stage for the vector unit's FP32 multiply path. It consumes the raw 48-bit significand product produced by the three-level CLA product accumulation, together with the product sign, the pre-normalisation exponent and upstream special-case flags. It emits an IEEE-754 binary32 result with round-to-nearest-even (RNE), flush-to-zero and exception flags. Input and output use valid/ready handshakes with full backpressure.

---
 rtl/vec_fp_pkg.sv | 31 +++
 rtl/vec_rne_rounder.sv | 47 ++++
 rtl/vec_fmul_round.sv | 89 ++++++++
 3 files changed

// File: rtl/vec_fp_pkg.sv
// Shared FP32 constants and the stage 1 payload for the vector multiply
// normalise-and-round path.
package vec_fp_pkg;

  localparam int FRAC_W    = 23;
  localparam int FP_EXP_W  = 8;
  localparam int SIG_W     = 24;
  localparam int PAY_EXP_W = 10;
  localparam int BIAS      = 127;
  localparam int FLAGS_W   = 3;

  localparam logic signed [PAY_EXP_W-1:0] EXP_MAX = 10'sd255;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Normalised significand plus the two rounding bits and upstream specials.
  typedef struct packed {
    logic                 sign;
    logic [PAY_EXP_W-1:0] exp;
    logic [SIG_W-1:0]     sig;
    logic                 guard;
    logic                 sticky;
    logic                 nan;
    logic                 inf;
    logic                 zero;
  } s1_payload_t;

endpackage

// File: rtl/vec_rne_rounder.sv
// Combinational round-to-nearest-even, range check and special-case select
// for one normalised FP32 product.
module vec_rne_rounder
  import vec_fp_pkg::*;
(
  input  s1_payload_t        pay,
  output logic [31:0]        result,
  output logic [FLAGS_W-1:0] flags
);

  logic                        rup;
  logic [SIG_W:0]              sig_r;
  logic signed [PAY_EXP_W-1:0] e_r;
  logic [FRAC_W-1:0]           frac;
  logic                        unused_hidden;

  assign rup   = pay.guard & (pay.sticky | pay.sig[0]);
  assign sig_r = {1'b0, pay.sig} + {{SIG_W{1'b0}}, rup};
  // A carry out of the significand means 1.111.. rounded up to 2.0.
  assign e_r   = pay.exp + {{(PAY_EXP_W-1){1'b0}}, sig_r[SIG_W]};
  assign frac  = sig_r[SIG_W] ? '0 : sig_r[FRAC_W-1:0];
  assign unused_hidden = sig_r[SIG_W-1];

  always_comb begin
    result = '0;
    flags  = '0;
    if (pay.nan) begin
      result = CANON_NAN;
    end else if (pay.inf) begin
      result = {pay.sign, {FP_EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (pay.zero) begin
      result = {pay.sign, 31'b0};
    end else if (e_r >= EXP_MAX) begin
      result         = {pay.sign, {FP_EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else if (e_r <= 10'sd0) begin
      result         = {pay.sign, 31'b0};
      flags[FLAG_UF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else begin
      result         = {pay.sign, e_r[FP_EXP_W-1:0], frac};
      flags[FLAG_NX] = pay.guard | pay.sticky;
    end
  end

endmodule

// File: rtl/vec_fmul_round.sv
// Two-stage normalise (stage 1) and round (stage 2) pipeline for the FP32
// multiply path, with full valid/ready backpressure.
module vec_fmul_round
  import vec_fp_pkg::*;
#(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MANT_W-1:0] mant_i,
  input  logic              nan_i,
  input  logic              inf_i,
  input  logic              zero_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       result_o,
  output logic [2:0]        flags_o
);

  // Handshake: a beat moves when valid and ready are both high at a rising
  // edge; valid never depends on ready, and a stalled stage holds its data.
  // in_ready_o is combinational from out_ready_i so a full pipe can take a
  // new beat in the same cycle the output drains.
  logic              s1_valid;
  logic              s2_ready;
  logic              hi;
  s1_payload_t       s1_pay;
  s1_payload_t       s1_next;
  logic [31:0]       rnd_result;
  logic [FLAGS_W-1:0] rnd_flags;

  assign s2_ready   = !out_valid_o | out_ready_i;
  assign in_ready_o = !s1_valid | s2_ready;

  assign hi = mant_i[MANT_W-1];

  always_comb begin
    s1_next        = '0;
    s1_next.sign   = sign_i;
    s1_next.nan    = nan_i;
    s1_next.inf    = inf_i;
    s1_next.zero   = zero_i;
    if (hi) begin
      s1_next.exp    = exp_i + EXP_W'(1);
      s1_next.sig    = mant_i[MANT_W-1 -: SIG_W];
      s1_next.guard  = mant_i[MANT_W-1-SIG_W];
      s1_next.sticky = |mant_i[MANT_W-2-SIG_W:0];
    end else begin
      s1_next.exp    = exp_i;
      s1_next.sig    = mant_i[MANT_W-2 -: SIG_W];
      s1_next.guard  = mant_i[MANT_W-2-SIG_W];
      s1_next.sticky = |mant_i[MANT_W-3-SIG_W:0];
    end
  end

  vec_rne_rounder u_rounder (
    .pay    (s1_pay),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_pay      <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      flags_o     <= '0;
    end else begin
      if (in_ready_o) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) s1_pay <= s1_next;
      end
      if (s2_ready) begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          result_o <= rnd_result;
          flags_o  <= rnd_flags;
        end
      end
    end
  end

endmodule
